// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Single-outstanding APB requester. A valid/ready request is turned into an
//   APB SETUP + ACCESS sequence. The result comes back as a one-cycle response
//   pulse. An optional ACCESS-phase timeout aborts transfers to a dead slave.
// Ports
//   PCLK, PRESET        : clock, synchronous active-high reset
//   req_*               : request port (valid/ready, write, addr, wdata, strb)
//   rsp_*               : response pulse (valid, rdata, err, timeout)
//   PSEL..PSTRB         : APB master outputs (all registered)
//   PRDATA/PREADY/PSLVERR : APB slave returns, only sampled in ACCESS
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int TO_WIDTH   = 5
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSTRB,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Counter value on the last permitted ACCESS cycle (unused when TIMEOUT==0).
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_t                r_state, w_state_nx;
  logic                  r_ready;
  logic                  r_psel, w_psel_nx;
  logic                  r_penable, w_penable_nx;
  logic                  r_pwrite, w_pwrite_nx;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nx;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nx;
  logic                  r_pstrb, w_pstrb_nx;
  logic                  r_rsp_valid, w_rsp_valid_nx;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nx;
  logic                  r_rsp_err, w_rsp_err_nx;
  logic                  r_rsp_to, w_rsp_to_nx;
  logic [TO_WIDTH-1:0]   r_cnt, w_cnt_nx;
  logic                  w_to_hit;

  assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    // Address/control and read data hold; response flags self-clear.
    w_state_nx     = r_state;
    w_psel_nx      = r_psel;
    w_penable_nx   = r_penable;
    w_pwrite_nx    = r_pwrite;
    w_paddr_nx     = r_paddr;
    w_pwdata_nx    = r_pwdata;
    w_pstrb_nx     = r_pstrb;
    w_rsp_valid_nx = 1'b0;
    w_rsp_rdata_nx = r_rsp_rdata;
    w_rsp_err_nx   = 1'b0;
    w_rsp_to_nx    = 1'b0;
    w_cnt_nx       = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_psel_nx    = 1'b0;
        w_penable_nx = 1'b0;
        if (req_valid && r_ready) begin
          w_pwrite_nx = req_write;
          w_paddr_nx  = req_addr;
          w_pwdata_nx = req_wdata;
          w_pstrb_nx  = req_strb;
          w_psel_nx   = 1'b1;
          w_state_nx  = SETUP;
        end
      end
      SETUP: begin
        w_penable_nx = 1'b1;
        w_cnt_nx     = '0;
        w_state_nx   = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority over the timeout on the same edge.
        if (PREADY) begin
          w_psel_nx      = 1'b0;
          w_penable_nx   = 1'b0;
          w_rsp_valid_nx = 1'b1;
          w_rsp_err_nx   = PSLVERR;
          w_rsp_rdata_nx = r_pwrite ? '0 : PRDATA;
          w_state_nx     = IDLE;
        end else if (w_to_hit) begin
          w_psel_nx      = 1'b0;
          w_penable_nx   = 1'b0;
          w_rsp_valid_nx = 1'b1;
          w_rsp_err_nx   = 1'b1;
          w_rsp_to_nx    = 1'b1;
          w_rsp_rdata_nx = '0;
          w_state_nx     = IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nx;
      // Registered ready tracks the state being entered, so it is high
      // alongside rsp_valid.
      r_ready     <= (w_state_nx == IDLE);
      r_psel      <= w_psel_nx;
      r_penable   <= w_penable_nx;
      r_pwrite    <= w_pwrite_nx;
      r_paddr     <= w_paddr_nx;
      r_pwdata    <= w_pwdata_nx;
      r_pstrb     <= w_pstrb_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_rdata <= w_rsp_rdata_nx;
      r_rsp_err   <= w_rsp_err_nx;
      r_rsp_to    <= w_rsp_to_nx;
      r_cnt       <= w_cnt_nx;
    end
  end

  assign req_ready   = r_ready;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Table of transfers (request + slave behaviour + expected response/timing)
//   applied in a loop with a response scoreboard, followed by hand-written
//   back-to-back and reset-during-ACCESS sequences.
module tb_apb_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req_valid, req_ready, req_write, req_strb;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE, PSTRB;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(16), .TO_WIDTH(5)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       strb;
    int         wait_n;   // ACCESS wait cycles before PREADY
    logic       never;    // slave never answers
    logic       slverr;
    logic [7:0] prdata;
    logic [7:0] e_rdata;
    logic       e_err;
    logic       e_to;
    int         e_acc;    // expected ACCESS cycles (PENABLE high)
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       to;
  } rsp_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  rsp_t sb_q [$];

  int   n_vec = 0;
  int   n_bad = 0;
  int   edges;
  logic rsp_flag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: advance past the rising edge, sample at the falling edge and
  // score any response against the queue head.
  task automatic tick();
    rsp_t e;
    @(posedge PCLK);
    edges++;
    @(negedge PCLK);
    rsp_flag = rsp_valid;
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata",   32'(rsp_rdata),   32'(e.rdata));
        chk("rsp_err",     32'(rsp_err),     32'(e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        chk("ready_w_rsp", 32'(req_ready),   32'd1);
      end
    end
  endtask

  initial begin
    int psel_n, pen_n, acc, stable_bad, lat, gap, rsp_b;
    logic got;
    vec_t v;

    vecs[0] = '{1'b1, 8'h03, 8'hA5, 1'b1,  3, 1'b0, 1'b0, 8'h5C, 8'h00, 1'b0, 1'b0,  4};
    vecs[1] = '{1'b0, 8'h03, 8'h00, 1'b0,  0, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0,  1};
    vecs[2] = '{1'b1, 8'h10, 8'h3C, 1'b1,  0, 1'b0, 1'b1, 8'h11, 8'h00, 1'b1, 1'b0,  1};
    vecs[3] = '{1'b0, 8'h20, 8'h00, 1'b0,  0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16};
    vecs[4] = '{1'b0, 8'h21, 8'h00, 1'b0, 15, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 16};
    vecs[5] = '{1'b0, 8'h7F, 8'h00, 1'b1,  1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b1, 1'b0,  2};
    vecs[6] = '{1'b1, 8'hFF, 8'h00, 1'b0,  2, 1'b0, 1'b0, 8'hEE, 8'h00, 1'b0, 1'b0,  3};

    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    edges = 0; rsp_flag = 1'b0;

    // Reset hold
    repeat (3) tick();
    chk("rst_psel",    32'(PSEL),      32'd0);
    chk("rst_penable", 32'(PENABLE),   32'd0);
    chk("rst_paddr",   32'(PADDR),     32'd0);
    chk("rst_pwdata",  32'(PWDATA),    32'd0);
    chk("rst_rsp",     32'(rsp_valid), 32'd0);
    chk("rst_ready",   32'(req_ready), 32'd0);
    PRESET = 1'b0;
    tick();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Table-driven transfers
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_strb = v.strb;
      req_valid = 1'b1;
      sb_q.push_back('{v.e_rdata, v.e_err, v.e_to});
      edges = 0;
      tick();                      // handshake edge
      req_valid = 1'b0;
      req_wdata = 8'hC3;           // must not leak into PWDATA
      psel_n = 0; pen_n = 0; acc = 0; stable_bad = 0; lat = 0; got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        if (PSEL) begin
          psel_n++;
          if (PADDR !== v.addr || PWRITE !== v.wr || PSTRB !== v.strb ||
              (v.wr && PWDATA !== v.wdata)) stable_bad++;
        end
        if (PENABLE) begin pen_n++; acc++; end
        if (PSEL && PENABLE) begin
          if (!v.never && acc == v.wait_n + 1) begin
            PREADY = 1'b1; PSLVERR = v.slverr; PRDATA = v.prdata;
          end else begin
            PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 8'hEE;
          end
        end else begin
          // noise outside ACCESS must be ignored
          PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 8'hEE;
        end
        tick();
        if (rsp_flag) begin got = 1'b1; lat = edges; end
      end
      chk("rsp_seen",    32'(got),        32'd1);
      chk("latency",     32'(lat),        32'(v.e_acc + 2));
      chk("psel_cycles", 32'(psel_n),     32'(v.e_acc + 1));
      chk("pen_cycles",  32'(pen_n),      32'(v.e_acc));
      chk("apb_stable",  32'(stable_bad), 32'd0);
      chk("psel_off",    32'(PSEL),       32'd0);
      tick();
      chk("rsp_pulse",   32'(rsp_valid),  32'd0);
      chk("rdata_hold",  32'(rsp_rdata),  32'(v.e_rdata));
    end

    // Back-to-back with req_valid held high
    req_write = 1'b0; req_addr = 8'h40; req_strb = 1'b0; req_valid = 1'b1;
    sb_q.push_back('{8'h77, 1'b0, 1'b0});
    sb_q.push_back('{8'h77, 1'b0, 1'b0});
    gap = 0; rsp_b = 0;
    for (int c = 0; c < 40 && rsp_b < 2; c++) begin
      PREADY = PSEL && PENABLE; PRDATA = 8'h77; PSLVERR = 1'b0;
      tick();
      if (rsp_flag) rsp_b++;
      if (rsp_b == 1 && !PSEL) gap++;
      if (rsp_b == 1 && PSEL) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("b2b_rsps", 32'(rsp_b), 32'd2);
    chk("b2b_gap",  32'(gap),   32'd1);
    tick();

    // Reset during ACCESS: transfer abandoned, no response
    PREADY = 1'b0; PSLVERR = 1'b0;
    req_write = 1'b1; req_addr = 8'h55; req_wdata = 8'h66; req_strb = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    chk("in_access", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    tick();
    chk("mid_rst_psel",    32'(PSEL),      32'd0);
    chk("mid_rst_penable", 32'(PENABLE),   32'd0);
    chk("mid_rst_paddr",   32'(PADDR),     32'd0);
    chk("mid_rst_pwdata",  32'(PWDATA),    32'd0);
    chk("mid_rst_pwrite",  32'(PWRITE),    32'd0);
    chk("mid_rst_pstrb",   32'(PSTRB),     32'd0);
    chk("mid_rst_ready",   32'(req_ready), 32'd0);
    chk("mid_rst_rsp",     32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata",   32'(rsp_rdata), 32'd0);
    PRESET = 1'b0;
    tick();
    chk("mid_rst_ready1", 32'(req_ready), 32'd1);
    repeat (3) tick();
    chk("post_rst_psel", 32'(PSEL), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
